ht_vote_sequencer: RTL and testbench
====================================

# ht_vote_sequencer

Controller that sequences the Hough voting phase of the HT pipeline. It accepts a binary edge map from upstream, walks every pixel in raster order, and issues one accumulator vote per theta step for each edge pixel. It then hands the finished accumulator to the downstream peak-detect/VGA stage over a req/ack pair, and clears the accumulator before accepting the next frame.

## Interface
Parameters:
- MATRIX_N, 80, pixels per row (X extent)
- MATRIX_M, 80, rows (Y extent)
- COORD_BITS, 7, width of X/Y coordinates; 2^COORD_BITS >= max(MATRIX_N, MATRIX_M)
- THETA_STEPS, 16, votes issued per edge pixel
- THETA_BITS, 4, theta index width; 2^THETA_BITS >= THETA_STEPS
- ACC_DEPTH, 2048, accumulator words to clear
- ACC_ADDR_BITS, 11, clear address width; 2^ACC_ADDR_BITS >= ACC_DEPTH

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-low
- ReqIn  in  1  upstream edge map valid (level)
- AckIn  out  1  one-cycle pulse: edge map fully consumed
- PixX  out  COORD_BITS  edge-map read column
- PixY  out  COORD_BITS  edge-map read row
- EdgeBit  in  1  edge flag at (PixX, PixY), combinational return, same cycle
- VoteValid  out  1  vote request to accumulator
- VoteReady  in  1  accumulator accepts vote
- VoteX, VoteY  out  COORD_BITS  vote pixel coordinates
- VoteTheta  out  THETA_BITS  vote theta index
- ClrEn  out  1  accumulator clear write enable
- ClrAddr  out  ACC_ADDR_BITS  clear address
- ReqOut  out  1  accumulator result ready (level)
- AckOut  in  1  downstream has taken the result
- Busy  out  1  state != IDLE

## Operation
- States: START, CLEAR, IDLE, SCAN, VOTE, FINISH, DONE. Outputs are registered or decoded from registered state only.
- START: entered on reset. All outputs 0. Goes unconditionally to CLEAR with ClrAddr=0.
- CLEAR: ClrEn=1, ClrAddr increments 0..ACC_DEPTH-1, one address per cycle, no stall. After address ACC_DEPTH-1, go to IDLE.
- IDLE: Busy=0. If ReqIn=1, go to SCAN with PixX=PixY=0.
- SCAN: sample EdgeBit for the current (PixX, PixY).
  - EdgeBit=0: advance pixel. PixX++; at MATRIX_N-1, wrap PixX to 0 and PixY++.
  - Last pixel (MATRIX_N-1, MATRIX_M-1) with EdgeBit=0: go to FINISH.
  - EdgeBit=1: latch VoteX/VoteY from PixX/PixY, set theta=0, go to VOTE. Pixel does not advance.
- VOTE: VoteValid=1, VoteTheta=theta.
  - On VoteValid&VoteReady with theta<THETA_STEPS-1: theta++.
  - On acceptance of theta=THETA_STEPS-1: last pixel goes to FINISH; otherwise advance pixel and go to SCAN.
- FINISH: AckIn=1 for exactly one cycle, then DONE.
- DONE: ReqOut=1 until AckOut is sampled high, then go to CLEAR. AckOut is ignored in all other states.
- ReqIn is only sampled in IDLE. If it is still high after DONE→CLEAR→IDLE, a new frame starts.

## Timing
- Reset: Reset=0 at a rising edge forces START and zeroes all counters and outputs on that edge, from any state. An in-flight vote is dropped and no AckIn is issued.
- Reset release: 1 START cycle, then ACC_DEPTH CLEAR cycles, then IDLE.
- ReqIn high in IDLE at edge k: SCAN from edge k with PixX=PixY=0.
- SCAN+VOTE duration with VoteReady held at 1: MATRIX_N*MATRIX_M + E*THETA_STEPS cycles, where E is the edge-pixel count.
- Backpressure: while VoteValid=1 and VoteReady=0, VoteX/VoteY/VoteTheta are held stable and VoteValid stays high.
- AckIn rises the cycle after the final scan/vote acceptance. ReqOut rises the following cycle.
- ReqOut falls on the edge that samples AckOut=1, and ClrEn=1 starts in the same cycle.
- Every counter wraps only at its parameter bound, never at the power-of-two width.

## Test plan
Parameters for all scenarios: MATRIX_N=4, MATRIX_M=3, THETA_STEPS=4, ACC_DEPTH=8.
- Reset held low 3 cycles -> all outputs 0. Release -> 1 START cycle, ClrEn high 8 cycles with ClrAddr 0..7, then Busy=0.
- Empty frame (ReqIn=1, EdgeBit=0 always) -> 12 SCAN cycles, VoteValid never high, single AckIn pulse, ReqOut=1. AckOut=1 -> ReqOut drops, 8 clear cycles.
- Single edge at (2,1) -> exactly 4 votes: VoteX=2, VoteY=1, VoteTheta 0,1,2,3. AckIn 16 cycles after SCAN entry.
- VoteReady=0 for 3 cycles while VoteTheta=1 -> VoteValid stays 1 and all vote fields stay constant. Total scan time grows by 3.
- All pixels edges -> 48 votes, last vote at (3,2) theta=3, scan duration 60 cycles, AckIn immediately after.
- Reset=0 during VOTE (theta=2) -> next edge all outputs 0 and no AckIn. Then a START/CLEAR sequence as in scenario 1.

Source files
------------

// File: rtl/ht_vote_sequencer.sv
// ht_vote_sequencer
// Sequences the Hough voting phase: clears the accumulator, scans the
// binary edge map in raster order, issues THETA_STEPS votes for every
// edge pixel, then hands the accumulator downstream over ReqOut/AckOut.
//
// state  | meaning
// -------+-----------------------------------------------------------
// START  | entered from reset, all outputs low, next cycle clears
// CLEAR  | ClrEn high, ClrAddr walks 0..ACC_DEPTH-1, one per cycle
// IDLE   | waiting for ReqIn, Busy low
// SCAN   | sample EdgeBit at (PixX, PixY), advance or start voting
// VOTE   | VoteValid high, theta steps on each accepted vote
// FINISH | one-cycle AckIn pulse to the edge-map producer
// DONE   | ReqOut high until AckOut, then clear for the next frame

module ht_vote_sequencer #(
    parameter int MATRIX_N      = 80,
    parameter int MATRIX_M      = 80,
    parameter int COORD_BITS    = 7,
    parameter int THETA_STEPS   = 16,
    parameter int THETA_BITS    = 4,
    parameter int ACC_DEPTH     = 2048,
    parameter int ACC_ADDR_BITS = 11
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     ReqIn,
    output logic                     AckIn,
    output logic [COORD_BITS-1:0]    PixX,
    output logic [COORD_BITS-1:0]    PixY,
    input  logic                     EdgeBit,
    output logic                     VoteValid,
    input  logic                     VoteReady,
    output logic [COORD_BITS-1:0]    VoteX,
    output logic [COORD_BITS-1:0]    VoteY,
    output logic [THETA_BITS-1:0]    VoteTheta,
    output logic                     ClrEn,
    output logic [ACC_ADDR_BITS-1:0] ClrAddr,
    output logic                     ReqOut,
    input  logic                     AckOut,
    output logic                     Busy
);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_IDLE   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_VOTE   = 3'd4,
        ST_FINISH = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Registered control outputs, loaded together with the state they belong to.
    typedef struct packed {
        logic clr_en;
        logic vote_valid;
        logic ack_in;
        logic req_out;
        logic busy;
    } out_t;

    // Bounds are explicit so counters wrap at the matrix size, not the field width.
    localparam logic [COORD_BITS-1:0]    LAST_X     = COORD_BITS'(MATRIX_N - 1);
    localparam logic [COORD_BITS-1:0]    LAST_Y     = COORD_BITS'(MATRIX_M - 1);
    localparam logic [THETA_BITS-1:0]    LAST_THETA = THETA_BITS'(THETA_STEPS - 1);
    localparam logic [ACC_ADDR_BITS-1:0] LAST_ADDR  = ACC_ADDR_BITS'(ACC_DEPTH - 1);

    state_t                   r_state;
    out_t                     r_out;
    logic [COORD_BITS-1:0]    r_pix_x;
    logic [COORD_BITS-1:0]    r_pix_y;
    logic [COORD_BITS-1:0]    r_vote_x;
    logic [COORD_BITS-1:0]    r_vote_y;
    logic [THETA_BITS-1:0]    r_theta;
    logic [ACC_ADDR_BITS-1:0] r_clr_addr;

    logic                     w_last_pix;
    logic                     w_last_theta;
    logic [COORD_BITS-1:0]    w_next_x;
    logic [COORD_BITS-1:0]    w_next_y;

    // Output pattern for each state; START and IDLE drive everything low.
    function automatic out_t outs_for(input state_t s);
        out_t o;
        o = '0;
        case (s)
            ST_CLEAR:  begin o.clr_en     = 1'b1; o.busy = 1'b1; end
            ST_SCAN:   begin                      o.busy = 1'b1; end
            ST_VOTE:   begin o.vote_valid = 1'b1; o.busy = 1'b1; end
            ST_FINISH: begin o.ack_in     = 1'b1; o.busy = 1'b1; end
            ST_DONE:   begin o.req_out    = 1'b1; o.busy = 1'b1; end
            default:   o = '0;
        endcase
        return o;
    endfunction

    assign w_last_pix   = (r_pix_x == LAST_X) && (r_pix_y == LAST_Y);
    assign w_last_theta = (r_theta == LAST_THETA);

    // Raster-order successor of the current pixel.
    always_comb begin
        w_next_x = r_pix_x + 1'b1;
        w_next_y = r_pix_y;
        if (r_pix_x == LAST_X) begin
            w_next_x = '0;
            w_next_y = r_pix_y + 1'b1;
        end
    end

    // Sequencer FSM: state, counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state    <= ST_START;
            r_out      <= '0;
            r_pix_x    <= '0;
            r_pix_y    <= '0;
            r_vote_x   <= '0;
            r_vote_y   <= '0;
            r_theta    <= '0;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_clr_addr <= '0;
                    r_state    <= ST_CLEAR;
                    r_out      <= outs_for(ST_CLEAR);
                end

                ST_CLEAR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_clr_addr <= '0;
                        r_state    <= ST_IDLE;
                        r_out      <= outs_for(ST_IDLE);
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (ReqIn) begin
                        r_pix_x <= '0;
                        r_pix_y <= '0;
                        r_state <= ST_SCAN;
                        r_out   <= outs_for(ST_SCAN);
                    end
                end

                ST_SCAN: begin
                    if (EdgeBit) begin
                        // Pixel stays put; it advances once its last vote is taken.
                        r_vote_x <= r_pix_x;
                        r_vote_y <= r_pix_y;
                        r_theta  <= '0;
                        r_state  <= ST_VOTE;
                        r_out    <= outs_for(ST_VOTE);
                    end else if (w_last_pix) begin
                        r_state <= ST_FINISH;
                        r_out   <= outs_for(ST_FINISH);
                    end else begin
                        r_pix_x <= w_next_x;
                        r_pix_y <= w_next_y;
                    end
                end

                ST_VOTE: begin
                    if (VoteReady) begin
                        if (!w_last_theta) begin
                            r_theta <= r_theta + 1'b1;
                        end else if (w_last_pix) begin
                            r_state <= ST_FINISH;
                            r_out   <= outs_for(ST_FINISH);
                        end else begin
                            r_pix_x <= w_next_x;
                            r_pix_y <= w_next_y;
                            r_state <= ST_SCAN;
                            r_out   <= outs_for(ST_SCAN);
                        end
                    end
                end

                ST_FINISH: begin
                    r_pix_x <= '0;
                    r_pix_y <= '0;
                    r_state <= ST_DONE;
                    r_out   <= outs_for(ST_DONE);
                end

                ST_DONE: begin
                    if (AckOut) begin
                        r_clr_addr <= '0;
                        r_state    <= ST_CLEAR;
                        r_out      <= outs_for(ST_CLEAR);
                    end
                end

                default: begin
                    r_state <= ST_START;
                    r_out   <= '0;
                end
            endcase
        end
    end

    assign AckIn     = r_out.ack_in;
    assign VoteValid = r_out.vote_valid;
    assign ClrEn     = r_out.clr_en;
    assign ReqOut    = r_out.req_out;
    assign Busy      = r_out.busy;
    assign PixX      = r_pix_x;
    assign PixY      = r_pix_y;
    assign VoteX     = r_vote_x;
    assign VoteY     = r_vote_y;
    assign VoteTheta = r_theta;
    assign ClrAddr   = r_clr_addr;

endmodule

// File: tb/tb_ht_vote_sequencer.sv
// Bench for ht_vote_sequencer on a 4x3 map, 4 theta steps, 8-word clear.
module tb_ht_vote_sequencer;

    localparam int N  = 4;
    localparam int M  = 3;
    localparam int T  = 4;
    localparam int D  = 8;
    localparam int CB = 3;
    localparam int TB = 3;
    localparam int AB = 4;

    logic          Clk;
    logic          Reset;
    logic          ReqIn;
    logic          AckIn;
    logic [CB-1:0] PixX;
    logic [CB-1:0] PixY;
    logic          EdgeBit;
    logic          VoteValid;
    logic          VoteReady;
    logic [CB-1:0] VoteX;
    logic [CB-1:0] VoteY;
    logic [TB-1:0] VoteTheta;
    logic          ClrEn;
    logic [AB-1:0] ClrAddr;
    logic          ReqOut;
    logic          AckOut;
    logic          Busy;

    ht_vote_sequencer #(
        .MATRIX_N(N), .MATRIX_M(M), .COORD_BITS(CB),
        .THETA_STEPS(T), .THETA_BITS(TB),
        .ACC_DEPTH(D), .ACC_ADDR_BITS(AB)
    ) dut (
        .Clk(Clk), .Reset(Reset), .ReqIn(ReqIn), .AckIn(AckIn),
        .PixX(PixX), .PixY(PixY), .EdgeBit(EdgeBit),
        .VoteValid(VoteValid), .VoteReady(VoteReady),
        .VoteX(VoteX), .VoteY(VoteY), .VoteTheta(VoteTheta),
        .ClrEn(ClrEn), .ClrAddr(ClrAddr),
        .ReqOut(ReqOut), .AckOut(AckOut), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [CB-1:0] x;
        logic [CB-1:0] y;
        logic [TB-1:0] t;
    } vote_t;

    typedef struct {
        logic [N*M-1:0] map;
        int             stall_theta;
        int             stall_len;
        int             exp_votes;
        int             exp_cycles;
    } vec_t;

    int             n_vec = 0;
    int             n_err = 0;
    vote_t          exp_q[$];
    logic [N*M-1:0] cur_map = '0;
    int             stall_theta = 0;
    int             stall_left = 0;
    int             vote_cnt = 0;
    logic           held_valid = 1'b0;
    vote_t          held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {8'h0, AckIn, PixX, PixY, VoteValid, VoteX, VoteY, VoteTheta,
                ClrEn, ClrAddr, ReqOut, Busy};
    endfunction

    // Edge-map memory: combinational read at the DUT's pixel address.
    always_comb begin
        EdgeBit = 1'b0;
        if (int'(PixX) < N && int'(PixY) < M)
            EdgeBit = cur_map[int'(PixY) * N + int'(PixX)];
    end

    // Accumulator side: backpressure injection and vote scoreboard.
    always @(negedge Clk) begin
        if (Reset) begin
            if (held_valid)
                chk("bp_hold", {VoteValid, VoteX, VoteY, VoteTheta}, {1'b1, held});
            if (VoteValid) begin
                if (stall_left > 0 && int'(VoteTheta) == stall_theta) begin
                    VoteReady  = 1'b0;
                    stall_left = stall_left - 1;
                    held       = {VoteX, VoteY, VoteTheta};
                    held_valid = 1'b1;
                end else begin
                    VoteReady  = 1'b1;
                    held_valid = 1'b0;
                    vote_cnt   = vote_cnt + 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_vote", {VoteX, VoteY, VoteTheta}, 32'hffff);
                    end else begin
                        chk("vote", {VoteX, VoteY, VoteTheta}, exp_q.pop_front());
                    end
                end
            end else begin
                VoteReady  = 1'b1;
                held_valid = 1'b0;
            end
        end else begin
            VoteReady  = 1'b1;
            held_valid = 1'b0;
        end
    end

    // Called at the first negedge of CLEAR; returns at the first IDLE negedge.
    task automatic check_clear();
        for (int i = 0; i < D; i++) begin
            chk("clear_step", {ClrEn, Busy, ClrAddr}, {1'b1, 1'b1, AB'(i)});
            @(negedge Clk);
        end
        chk("idle_after_clear", {ClrEn, Busy, ClrAddr}, 32'h0);
    endtask

    task automatic run_frame(input vec_t v);
        int cyc;
        cur_map = v.map;
        exp_q.delete();
        for (int y = 0; y < M; y++)
            for (int x = 0; x < N; x++)
                if (v.map[y * N + x])
                    for (int t = 0; t < T; t++)
                        exp_q.push_back({CB'(x), CB'(y), TB'(t)});
        stall_theta = v.stall_theta;
        stall_left  = v.stall_len;
        vote_cnt    = 0;
        ReqIn = 1'b1;
        @(negedge Clk);
        ReqIn = 1'b0;
        cyc = 0;
        while (!AckIn && cyc < 300) begin
            cyc++;
            @(negedge Clk);
        end
        chk("scan_cycles", cyc, v.exp_cycles);
        chk("vote_count", vote_cnt, v.exp_votes);
        chk("votes_left", exp_q.size(), 0);
        @(negedge Clk);
        chk("ackin_pulse", {AckIn, ReqOut}, {1'b0, 1'b1});
        @(negedge Clk);
        chk("reqout_held", ReqOut, 1);
        AckOut = 1'b1;
        @(negedge Clk);
        AckOut = 1'b0;
        chk("reqout_drop", ReqOut, 0);
        check_clear();
    endtask

    vec_t vecs[6];

    initial begin
        int cnt;
        vecs[0] = '{map: 12'h000, stall_theta: 0, stall_len: 0, exp_votes: 0,  exp_cycles: 12};
        vecs[1] = '{map: 12'h040, stall_theta: 0, stall_len: 0, exp_votes: 4,  exp_cycles: 16};
        vecs[2] = '{map: 12'h040, stall_theta: 1, stall_len: 3, exp_votes: 4,  exp_cycles: 19};
        vecs[3] = '{map: 12'hFFF, stall_theta: 0, stall_len: 0, exp_votes: 48, exp_cycles: 60};
        vecs[4] = '{map: 12'h801, stall_theta: 0, stall_len: 0, exp_votes: 8,  exp_cycles: 20};
        vecs[5] = '{map: 12'h088, stall_theta: 3, stall_len: 2, exp_votes: 8,  exp_cycles: 22};

        Reset = 1'b0; ReqIn = 1'b0; AckOut = 1'b0; VoteReady = 1'b1;

        // Reset held for three edges, then the START/CLEAR bring-up.
        repeat (3) begin
            @(negedge Clk);
            chk("reset_outs", all_outs(), 32'h0);
        end
        Reset = 1'b1;
        @(negedge Clk);
        check_clear();

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset in the middle of a vote burst.
        cur_map = 12'h040;
        exp_q.delete();
        for (int t = 0; t < T; t++) exp_q.push_back({CB'(2), CB'(1), TB'(t)});
        ReqIn = 1'b1;
        @(negedge Clk);
        ReqIn = 1'b0;
        cnt = 0;
        while (!(VoteValid && VoteTheta == TB'(2)) && cnt < 200) begin
            cnt++;
            @(negedge Clk);
        end
        chk("reach_theta2", (cnt < 200), 1);
        Reset = 1'b0;
        @(negedge Clk);
        chk("midvote_reset_outs", all_outs(), 32'h0);
        @(negedge Clk);
        chk("midvote_reset_hold", all_outs(), 32'h0);
        Reset = 1'b1;
        exp_q.delete();
        cur_map = '0;
        @(negedge Clk);
        check_clear();
        @(negedge Clk);
        chk("no_late_ackin", {AckIn, ReqOut, Busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
